ifu_line_fetch: RTL

IFU_LINE_FETCH -- requirements
Module: ifu_line_fetch

---
 rtl/ifu_pkg.sv | 27 ++
 rtl/ifu_line_buf.sv | 45 ++++
 rtl/ifu_line_fetch.sv | 102 ++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch line buffer: FSM encoding,
// default parameters and PC bit-field positions.
package ifu_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam int          IFU_LINE_W   = 128;

    localparam int OFF_MSB        = 3;
    localparam int OFF_LSB        = 0;
    localparam int WORD_MSB       = 3;
    localparam int WORD_LSB       = 2;
    localparam int TAG_MSB        = 31;
    localparam int TAG_LSB        = 4;
    localparam int TAG_W          = TAG_MSB - TAG_LSB + 1;
    localparam int WORDS_PER_LINE = IFU_LINE_W / 32;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_MISS = 2'd1;
    localparam logic [1:0] ST_KILL = 2'd2;

    typedef enum logic [1:0] {
        RUN  = ST_RUN,
        MISS = ST_MISS,
        KILL = ST_KILL
    } state_e;

endpackage

// File: rtl/ifu_line_buf.sv
// Single-entry I-cache line buffer: holds one line with its tag, reports a hit
// for the current PC and selects the addressed 32-bit word.
module ifu_line_buf
    import ifu_pkg::*;
#(
    parameter int LINE_W = IFU_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [LINE_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              inv,
    input  logic [TAG_W-1:0]  pc_tag,
    input  logic [1:0]        pc_word,
    output logic              hit,
    output logic [31:0]       inst
);

    logic [LINE_W-1:0] buf_data;
    logic [TAG_W-1:0]  buf_tag;
    logic              buf_v;

    // Invalidate wins over a same-cycle fill so fence.i never leaves a stale line.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v <= 1'b0;
        end else if (inv) begin
            buf_v <= 1'b0;
        end else if (wr_en) begin
            buf_v <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_data <= wr_data;
            buf_tag  <= wr_tag;
        end
    end

    assign hit  = buf_v && (pc_tag == buf_tag);
    assign inst = buf_data[32*pc_word +: 32];

endmodule

// File: rtl/ifu_line_fetch.sv
// Instruction fetch front end: PC, miss/kill sequencing against a non-abortable
// I-cache, and handoff of one instruction per cycle to decode.
//
//   state | meaning
//   RUN   | serving instructions from the line buffer; a miss issues a request
//   MISS  | request outstanding; the returned line fills the buffer
//   KILL  | request outstanding but stale (redirect/flush); the line is dropped
module ifu_line_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int          LINE_W   = IFU_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              flush_line,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    output logic              icache_req_valid,
    output logic [31:0]       icache_req_addr,
    input  logic [LINE_W-1:0] icache_rdata,
    input  logic              icache_ready
);

    state_e      state;
    logic [31:0] pc;
    logic [31:0] target;
    logic        hit;
    logic        fire;
    logic        wr_en;

    assign target    = redirect_pc & 32'hFFFF_FFFC;
    assign out_valid = (state == RUN) && hit && !redirect_valid && !flush_line;
    assign fire      = out_valid && out_ready;
    assign out_pc    = pc;
    // A flush landing on the response cycle drops the line; the PC re-misses in RUN.
    assign wr_en     = (state == MISS) && icache_ready && !flush_line;

    ifu_line_buf #(
        .LINE_W (LINE_W)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (icache_rdata),
        .wr_tag  (icache_req_addr[TAG_MSB:TAG_LSB]),
        .inv     (flush_line),
        .pc_tag  (pc[TAG_MSB:TAG_LSB]),
        .pc_word (pc[WORD_MSB:WORD_LSB]),
        .hit     (hit),
        .inst    (out_inst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc               <= RESET_PC;
            state            <= RUN;
            icache_req_valid <= 1'b0;
            icache_req_addr  <= 32'h0;
        end else begin
            if (redirect_valid) begin
                pc <= target;
            end else if (fire) begin
                pc <= pc + 32'd4;
            end

            case (state)
                RUN: begin
                    // Only miss on a PC that is not about to change or be invalidated.
                    if (!hit && !redirect_valid && !flush_line) begin
                        state            <= MISS;
                        icache_req_valid <= 1'b1;
                        icache_req_addr  <= {pc[TAG_MSB:TAG_LSB], 4'b0000};
                    end
                end
                MISS: begin
                    if (icache_ready) begin
                        icache_req_valid <= 1'b0;
                        state            <= RUN;
                    end else if (redirect_valid || flush_line) begin
                        state <= KILL;
                    end
                end
                KILL: begin
                    if (icache_ready) begin
                        icache_req_valid <= 1'b0;
                        state            <= RUN;
                    end
                end
                default: begin
                    icache_req_valid <= 1'b0;
                    state            <= RUN;
                end
            endcase
        end
    end

endmodule
